top2_frame_ctrl: RTL and testbench

- Frame-based controller for a running top-two value tracker.
- Accepts a sample stream with valid/ready and a last flag, and sequences the tracker through clear → accumulate → report.
- Returns, per frame, the largest and second-largest distinct values and their occurrence counts over a result handshake.
- Sits between a sample source (ADC or packet field extractor) and a statistics consumer.

---
 rtl/top2_pkg.sv | 20 ++
 rtl/top2_tracker.sv | 63 ++++++
 rtl/top2_frame_ctrl.sv | 101 ++++++++++
 tb/tb_top2_frame_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/top2_pkg.sv
// Shared definitions for the top-two frame controller and its tracker:
// FSM state encoding, default data/counter widths and the frame-length width.
package top2_pkg;

  // Default sample width and occurrence-counter width.
  localparam int DEF_DW = 8;
  localparam int DEF_CW = 8;

  // Width of the optional per-frame sample counter (saturates at all ones).
  localparam int LEN_W = 16;

  // Controller states: IDLE waits for the first sample of a frame, RUN
  // accumulates the rest, REPORT holds the result until it is taken.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

endpackage : top2_pkg

// File: rtl/top2_tracker.sv
// Running top-two tracker: keeps the largest value and the largest value
// strictly below it, each with a saturating occurrence count.
// clr empties the tracker and has priority over upd.
module top2_tracker
  import top2_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          upd,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] max,
  output logic [CW-1:0] max_cnt,
  output logic [DW-1:0] sec,
  output logic [CW-1:0] sec_cnt,
  output logic          sec_vld
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_SAT = '1;

  // Separate occupancy flag so that a sample value of 0 is tracked like any other.
  logic max_vld;

  // Apply one accepted sample in priority order, or empty the tracker.
  // NOTE: every register here is assigned with <= so all updates in this
  // block see the pre-edge values (e.g. promotion copies the old max/count).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max     <= '0;
      max_cnt <= '0;
      max_vld <= 1'b0;
      sec     <= '0;
      sec_cnt <= '0;
      sec_vld <= 1'b0;
    end else if (upd) begin
      if (!max_vld) begin
        max     <= x;
        max_cnt <= CNT_ONE;
        max_vld <= 1'b1;
      end else if (x > max) begin
        // New maximum: the old maximum becomes the runner-up with its count.
        sec     <= max;
        sec_cnt <= max_cnt;
        sec_vld <= 1'b1;
        max     <= x;
        max_cnt <= CNT_ONE;
      end else if (x == max) begin
        if (max_cnt != CNT_SAT) max_cnt <= max_cnt + CNT_ONE;
      end else if (!sec_vld || (x > sec)) begin
        sec     <= x;
        sec_cnt <= CNT_ONE;
        sec_vld <= 1'b1;
      end else if (x == sec) begin
        if (sec_cnt != CNT_SAT) sec_cnt <= sec_cnt + CNT_ONE;
      end
    end
  end

endmodule : top2_tracker

// File: rtl/top2_frame_ctrl.sv
// Frame controller around the top-two tracker. Accepts samples over a
// valid/ready stream delimited by in_last, then presents the frame's largest
// and second-largest distinct values with counts over a result handshake.
// Optional build macro: TOP2_FRAME_LEN_EN adds res_len, the saturating count
// of accepted samples in the frame.
module top2_frame_ctrl
  import top2_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_max,
  output logic [CW-1:0]    res_max_cnt,
  output logic [DW-1:0]    res_sec,
  output logic [CW-1:0]    res_sec_cnt,
  output logic             res_sec_vld
`ifdef TOP2_FRAME_LEN_EN
  ,
  output logic [LEN_W-1:0] res_len
`endif
);

  state_t state;
  logic   accept;
  logic   res_hs;

  assign accept = in_valid && in_ready;
  assign res_hs = res_valid && res_ready;

  // Sequence IDLE -> RUN -> REPORT; in_ready and res_valid are registered
  // decodes of the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_RUN: begin
          if (accept) begin
            state     <= in_last ? S_REPORT : S_RUN;
            in_ready  <= !in_last;
            res_valid <= in_last;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // The tracker registers feed the result outputs directly; since in_ready is
  // low in REPORT nothing can update them until the handshake clears them.
  top2_tracker #(
    .DW(DW),
    .CW(CW)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clr     (res_hs),
    .upd     (accept),
    .x       (in_data),
    .max     (res_max),
    .max_cnt (res_max_cnt),
    .sec     (res_sec),
    .sec_cnt (res_sec_cnt),
    .sec_vld (res_sec_vld)
  );

`ifdef TOP2_FRAME_LEN_EN
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  // Count accepted samples of the current frame, cleared with the tracker.
  always_ff @(posedge clk) begin
    if (rst || res_hs) begin
      res_len <= '0;
    end else if (accept && (res_len != LEN_SAT)) begin
      res_len <= res_len + LEN_W'(1);
    end
  end
`endif

endmodule : top2_frame_ctrl

// File: tb/tb_top2_frame_ctrl.sv
// Directed self-checking bench for top2_frame_ctrl. A default-width instance
// and a CW=2 instance share the same stimulus so saturation can be exercised
// with short frames.
module tb_top2_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       res_ready = 1'b0;

  logic       in_ready, res_valid, res_sec_vld;
  logic [7:0] res_max, res_sec, res_max_cnt, res_sec_cnt;

  logic       c2_in_ready, c2_res_valid, c2_res_sec_vld;
  logic [7:0] c2_res_max, c2_res_sec;
  logic [1:0] c2_res_max_cnt, c2_res_sec_cnt;

`ifdef TOP2_FRAME_LEN_EN
  logic [15:0] res_len, c2_res_len;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  top2_frame_ctrl #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_max(res_max), .res_max_cnt(res_max_cnt),
    .res_sec(res_sec), .res_sec_cnt(res_sec_cnt), .res_sec_vld(res_sec_vld)
`ifdef TOP2_FRAME_LEN_EN
    , .res_len(res_len)
`endif
  );

  top2_frame_ctrl #(.DW(8), .CW(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(c2_in_ready),
    .res_valid(c2_res_valid), .res_ready(res_ready),
    .res_max(c2_res_max), .res_max_cnt(c2_res_max_cnt),
    .res_sec(c2_res_sec), .res_sec_cnt(c2_res_sec_cnt), .res_sec_vld(c2_res_sec_vld)
`ifdef TOP2_FRAME_LEN_EN
    , .res_len(c2_res_len)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one sample at a falling edge and hold it until it is accepted.
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the falling edge after the last sample: check the result on
  // both instances, then take it and confirm the return to IDLE.
  task automatic expect_res(input string tag,
                            input logic [7:0] mx, input logic [7:0] mc,
                            input logic [7:0] sc, input logic [7:0] scn, input logic sv,
                            input logic [1:0] c2_mc, input logic [1:0] c2_scn,
                            input logic [15:0] len);
    check({tag, ".res_valid"},   {31'b0, res_valid},   32'd1);
    check({tag, ".in_ready"},    {31'b0, in_ready},    32'd0);
    check({tag, ".res_max"},     {24'b0, res_max},     {24'b0, mx});
    check({tag, ".max_cnt"},     {24'b0, res_max_cnt}, {24'b0, mc});
    check({tag, ".res_sec"},     {24'b0, res_sec},     {24'b0, sc});
    check({tag, ".sec_cnt"},     {24'b0, res_sec_cnt}, {24'b0, scn});
    check({tag, ".sec_vld"},     {31'b0, res_sec_vld}, {31'b0, sv});
    check({tag, ".c2_max_cnt"},  {30'b0, c2_res_max_cnt}, {30'b0, c2_mc});
    check({tag, ".c2_sec_cnt"},  {30'b0, c2_res_sec_cnt}, {30'b0, c2_scn});
`ifdef TOP2_FRAME_LEN_EN
    check({tag, ".res_len"},     {16'b0, res_len},     {16'b0, len});
`else
    if (len == 16'hFFFF) $display("[TB] unexpected length %0d", len);
`endif
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".done_valid"},  {31'b0, res_valid},   32'd0);
    check({tag, ".done_ready"},  {31'b0, in_ready},    32'd1);
    check({tag, ".cleared_max"}, {24'b0, res_max},     32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready",  {31'b0, in_ready},    32'd1);
    check("rst.res_valid", {31'b0, res_valid},   32'd0);
    check("rst.res_max",   {24'b0, res_max},     32'd0);
    check("rst.max_cnt",   {24'b0, res_max_cnt}, 32'd0);
    check("rst.sec_vld",   {31'b0, res_sec_vld}, 32'd0);

    // Frame 3,7,7,5,2 with res_ready already high before the result exists.
    res_ready = 1'b1;
    send(8'd3, 1'b0);
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    send(8'd5, 1'b0);
    check("f1.no_early_valid", {31'b0, res_valid}, 32'd0);
    in_valid = 1'b1; in_data = 8'd2; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    expect_res("f1", 8'd7, 8'd2, 8'd5, 8'd1, 1'b1, 2'd2, 2'd1, 16'd5);

    // All-zero frame: zeros are counted, no runner-up.
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    expect_res("zeros", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 2'd3, 2'd0, 16'd3);

    // Decreasing values exercise the runner-up equal and no-change paths.
    send(8'd5, 1'b0);
    send(8'd3, 1'b0);
    send(8'd3, 1'b0);
    send(8'd1, 1'b1);
    expect_res("desc", 8'd5, 8'd1, 8'd3, 8'd2, 1'b1, 2'd1, 2'd2, 16'd4);

    // Promotion 4,4,9 followed by back-pressure with a pending sample 8.
    send(8'd4, 1'b0);
    send(8'd4, 1'b0);
    send(8'd9, 1'b1);
    in_valid = 1'b1; in_data = 8'd8; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready",  {31'b0, in_ready},    32'd0);
      check("bp.res_valid", {31'b0, res_valid},   32'd1);
      check("bp.res_max",   {24'b0, res_max},     32'd9);
      check("bp.max_cnt",   {24'b0, res_max_cnt}, 32'd1);
      check("bp.res_sec",   {24'b0, res_sec},     32'd4);
      check("bp.sec_cnt",   {24'b0, res_sec_cnt}, 32'd2);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp.release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    expect_res("bp_next", 8'd8, 8'd1, 8'd0, 8'd0, 1'b0, 2'd1, 2'd0, 16'd1);

    // Five samples of 6: CW=2 instance saturates at 3.
    for (int i = 0; i < 4; i++) send(8'd6, 1'b0);
    send(8'd6, 1'b1);
    expect_res("sat_max", 8'd6, 8'd5, 8'd0, 8'd0, 1'b0, 2'd3, 2'd0, 16'd5);

    // Saturated max count carried into the runner-up on promotion.
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
    send(8'd9, 1'b1);
    expect_res("sat_promo", 8'd9, 8'd1, 8'd1, 8'd4, 1'b1, 2'd1, 2'd3, 16'd5);

    // Runner-up count saturation.
    send(8'd9, 1'b0);
    for (int i = 0; i < 4; i++) send(8'd2, 1'b0);
    send(8'd2, 1'b1);
    expect_res("sat_sec", 8'd9, 8'd1, 8'd2, 8'd5, 1'b1, 2'd1, 2'd3, 16'd6);

    // Reset mid-frame discards the partial frame.
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst.in_ready",  {31'b0, in_ready},    32'd1);
    check("mid_rst.res_valid", {31'b0, res_valid},   32'd0);
    check("mid_rst.res_max",   {24'b0, res_max},     32'd0);
    check("mid_rst.max_cnt",   {24'b0, res_max_cnt}, 32'd0);
    check("mid_rst.res_sec",   {24'b0, res_sec},     32'd0);
    check("mid_rst.sec_cnt",   {24'b0, res_sec_cnt}, 32'd0);
    check("mid_rst.sec_vld",   {31'b0, res_sec_vld}, 32'd0);
    send(8'd5, 1'b1);
    expect_res("post_rst", 8'd5, 8'd1, 8'd0, 8'd0, 1'b0, 2'd1, 2'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_top2_frame_ctrl
